// File: rtl/cmem_arbiter.sv
// Two-port arbiter for the shared conv layer memory: one access per cycle,
// locked bursts with a bounded lock length, registered memory pins, 2-cycle reads.
module cmem_arb_port #(
  parameter bit ID = 1'b0
) (
  input  logic gnt_any,
  input  logic gid,
  input  logic tag_vld,
  input  logic tag_id,
  output logic gnt,
  output logic rvalid
);
  assign gnt    = gnt_any & (gid == ID);
  assign rvalid = tag_vld & (tag_id == ID);
endmodule

module cmem_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 20,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [2:0]    r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [2:0]    r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          cwr,
  output logic          crd,
  output logic [2:0]    csel,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd
);
  localparam int NUM_PORTS = 2;
  localparam int STAGES    = 2;
  localparam int CW        = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_LOCK);

  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic          req;
    logic          lock;
    logic          we;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t [NUM_PORTS-1:0] rq;
  assign rq[0] = {r0_req, r0_lock, r0_we, r0_sel, r0_addr, r0_wdata};
  assign rq[1] = {r1_req, r1_lock, r1_we, r1_sel, r1_addr, r1_wdata};

  state_t        state, state_nxt;
  logic [CW-1:0] lock_cnt, cnt_nxt, cnt_inc;
  logic          last, last_nxt;
  logic          gnt_any, gid;
  req_t          win;
  logic          rd_issue;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] id_pipe;

  logic [NUM_PORTS-1:0] gnt, rvalid;

  // Winner decode: an owner excludes the other side; FREE ties go to the
  // requester that was not granted last.
  always_comb begin
    gnt_any = 1'b0;
    gid     = 1'b0;
    case (state)
      OWN0: begin gnt_any = rq[0].req; gid = 1'b0; end
      OWN1: begin gnt_any = rq[1].req; gid = 1'b1; end
      default: begin
        gnt_any = rq[0].req | rq[1].req;
        gid     = (rq[0].req & rq[1].req) ? ~last : rq[1].req;
      end
    endcase
    if (reset) gnt_any = 1'b0;
  end

  assign win      = rq[gid];
  assign rd_issue = gnt_any & ~win.we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FREE;
      lock_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
      last     <= last_nxt;
    end
  end

  // Forced release only when the other side is waiting; otherwise the count saturates.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    last_nxt  = last;
    if (state == FREE) cnt_inc = CW'(1);
    else if (lock_cnt >= MAXC) cnt_inc = lock_cnt;
    else cnt_inc = lock_cnt + CW'(1);
    if (gnt_any) begin
      last_nxt = gid;
      if (win.lock && !((cnt_inc >= MAXC) && rq[!gid].req)) begin
        state_nxt = gid ? OWN1 : OWN0;
        cnt_nxt   = cnt_inc;
      end else begin
        state_nxt = FREE;
        cnt_nxt   = '0;
      end
    end else if (state != FREE) begin
      state_nxt = FREE;
      cnt_nxt   = '0;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    cmem_arb_port #(.ID(1'(i))) u_port (
      .gnt_any (gnt_any),
      .gid     (gid),
      .tag_vld (vld_pipe[STAGES]),
      .tag_id  (id_pipe[STAGES]),
      .gnt     (gnt[i]),
      .rvalid  (rvalid[i])
    );
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];

  // Memory pins and read-return pipe; the tag follows each read so returns
  // land on the right requester even after ownership changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= 3'd0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      rdata    <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      cwr  <= gnt_any & win.we;
      crd  <= rd_issue;
      csel <= gnt_any ? win.sel : 3'd0;
      if (gnt_any && win.we) begin
        caddr_wr <= win.addr;
        cdata_wr <= win.wdata;
      end
      if (rd_issue) caddr_rd <= win.addr;
      vld_pipe <= {vld_pipe[1], rd_issue};
      id_pipe  <= {id_pipe[1], gid};
      if (vld_pipe[1]) rdata <= cdata_rd;
    end
  end
endmodule

// File: tb/tb_cmem_arbiter.sv
// Scoreboard bench for cmem_arbiter: per-cycle stimulus pushes expected grants,
// memory strobes and read returns; a negedge monitor pops and compares them.
module tb_cmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;

  typedef struct {
    logic          req;
    logic          lock;
    logic          we;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } breq_t;

  typedef struct {
    int            cyc;
    logic [1:0]    v;
    logic          we;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic r0_req = 0, r0_lock = 0, r0_we = 0, r1_req = 0, r1_lock = 0, r1_we = 0;
  logic [2:0] r0_sel = 0, r1_sel = 0;
  logic [AW-1:0] r0_addr = 0, r1_addr = 0;
  logic [DW-1:0] r0_wdata = 0, r1_wdata = 0;
  logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, cwr, crd;
  logic [DW-1:0] rdata, cdata_wr, cdata_rd;
  logic [2:0] csel;
  logic [AW-1:0] caddr_wr, caddr_rd;

  int cyc = 0;
  int checks = 0, errors = 0;
  exp_t gq[$], mq[$], rq[$];

  cmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_sel(r0_sel),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_sel(r1_sel),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr),
    .caddr_rd(caddr_rd), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return DW'(a) * 20'd7 + 20'h1234;
  endfunction

  assign cdata_rd = crd ? data_of(caddr_rd) : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic breq_t idle();
    breq_t r;
    r = '{req: 1'b0, lock: 1'b0, we: 1'b0, sel: 3'd0, addr: '0, wdata: '0};
    return r;
  endfunction

  function automatic breq_t rd(input logic [2:0] s, input logic [AW-1:0] a, input logic l);
    breq_t r;
    r = '{req: 1'b1, lock: l, we: 1'b0, sel: s, addr: a, wdata: '0};
    return r;
  endfunction

  function automatic breq_t wr(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    breq_t r;
    r = '{req: 1'b1, lock: 1'b0, we: 1'b1, sel: s, addr: a, wdata: d};
    return r;
  endfunction

  // Called just after a rising edge: drive one cycle, queue what the spec says
  // must happen now (grant), next cycle (pins) and two cycles on (return).
  task automatic step(input breq_t a, input breq_t b, input logic [1:0] eg);
    breq_t w;
    exp_t e;
    {r0_req, r0_lock, r0_we, r0_sel, r0_addr, r0_wdata} = {a.req, a.lock, a.we, a.sel, a.addr, a.wdata};
    {r1_req, r1_lock, r1_we, r1_sel, r1_addr, r1_wdata} = {b.req, b.lock, b.we, b.sel, b.addr, b.wdata};
    w = eg[1] ? b : a;
    e = '{cyc: cyc, v: eg, we: 1'b0, sel: 3'd0, addr: '0, data: '0};
    gq.push_back(e);
    e = '{cyc: cyc + 1, v: {1'b0, eg != 2'b00}, we: w.we, sel: w.sel, addr: w.addr, data: w.wdata};
    mq.push_back(e);
    e = '{cyc: cyc + 2, v: (eg != 2'b00 && !w.we) ? eg : 2'b00, we: 1'b0, sel: 3'd0,
          addr: w.addr, data: data_of(w.addr)};
    rq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (gq.size() != 0 && gq[0].cyc == cyc) begin
      e = gq.pop_front();
      check("gnt", {30'd0, r1_gnt, r0_gnt}, {30'd0, e.v});
    end
    if (mq.size() != 0 && mq[0].cyc == cyc) begin
      e = mq.pop_front();
      check("cwr", {31'd0, cwr}, {31'd0, e.v[0] & e.we});
      check("crd", {31'd0, crd}, {31'd0, e.v[0] & ~e.we});
      check("csel", {29'd0, csel}, {29'd0, e.v[0] ? e.sel : 3'd0});
      if (e.v[0] && e.we) begin
        check("caddr_wr", {20'd0, caddr_wr}, {20'd0, e.addr});
        check("cdata_wr", {12'd0, cdata_wr}, {12'd0, e.data});
      end
      if (e.v[0] && !e.we) check("caddr_rd", {20'd0, caddr_rd}, {20'd0, e.addr});
    end
    if (rq.size() != 0 && rq[0].cyc == cyc) begin
      e = rq.pop_front();
      check("rvalid", {30'd0, r1_rvalid, r0_rvalid}, {30'd0, e.v});
      if (e.v != 2'b00) check("rdata", {12'd0, rdata}, {12'd0, e.data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, cwr, crd, csel}, 32'd0);
    check("rst_bus", {8'd0, caddr_wr, caddr_rd}, 32'd0);
    check("rst_data", {12'd0, rdata | cdata_wr}, 32'd0);
    reset = 1'b0;

    // Round robin from reset: requester 0 wins the first tie.
    for (int i = 0; i < 6; i++)
      step(rd(3'd2, 12'h100 + 12'(i), 1'b0), rd(3'd3, 12'h200 + 12'(i), 1'b0),
           (i % 2 == 0) ? 2'b01 : 2'b10);
    step(idle(), idle(), 2'b00);
    step(idle(), idle(), 2'b00);

    // Locked 4-read pooling window against a waiting requester 1.
    step(rd(3'd2, 12'h000, 1'b1), rd(3'd4, 12'h300, 1'b0), 2'b01);
    step(rd(3'd2, 12'h001, 1'b1), rd(3'd4, 12'h300, 1'b0), 2'b01);
    step(rd(3'd2, 12'h040, 1'b1), rd(3'd4, 12'h300, 1'b0), 2'b01);
    step(rd(3'd2, 12'h041, 1'b1), rd(3'd4, 12'h300, 1'b0), 2'b01);
    step(idle(), rd(3'd4, 12'h300, 1'b0), 2'b10);
    step(idle(), idle(), 2'b00);

    // Single write, then two idle cycles for the strobe to drop.
    step(wr(3'd1, 12'h041, 20'h0ABCD), idle(), 2'b01);
    step(idle(), idle(), 2'b00);
    step(idle(), idle(), 2'b00);

    // Forced release: r1 locks for 6 requests, r0 gets one slot after 4.
    step(idle(), rd(3'd5, 12'h400, 1'b1), 2'b10);
    for (int i = 1; i < 4; i++)
      step(rd(3'd6, 12'h050, 1'b0), rd(3'd5, 12'h400 + 12'(i), 1'b1), 2'b10);
    step(rd(3'd6, 12'h050, 1'b0), rd(3'd5, 12'h404, 1'b1), 2'b01);
    step(idle(), rd(3'd5, 12'h404, 1'b1), 2'b10);
    step(idle(), rd(3'd5, 12'h405, 1'b1), 2'b10);
    step(idle(), idle(), 2'b00);
    step(idle(), idle(), 2'b00);

    // Reset the cycle after a read grant; pending return must vanish.
    step(rd(3'd1, 12'h060, 1'b0), idle(), 2'b01);
    {r0_req, r1_req} = 2'b00;
    #1;
    reset = 1'b1;
    gq.delete();
    mq.delete();
    rq.delete();
    #1;
    check("mid_rst_crd", {31'd0, crd}, 32'd0);
    check("mid_rst_rv", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    check("mid_rst_rdata", {12'd0, rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_rv", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
      step(idle(), idle(), 2'b00);
    end
    // After reset the pointer is 1 again, so requester 0 wins the tie.
    step(rd(3'd1, 12'h070, 1'b0), rd(3'd2, 12'h071, 1'b0), 2'b01);
    step(idle(), rd(3'd2, 12'h071, 1'b0), 2'b10);

    repeat (4) @(posedge clk);
    #1;
    check("drain", gq.size() + mq.size() + rq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
